// File: rtl/mtp_pkg.sv
// mtp_pkg: shared types and constants for the MTP write controller and the
// power-up init sequencer.
//   mtp_wr_state_e : write controller states
//   ERR_*          : err_code values reported with wr_done
//   PTR_*          : well-known word pointers into the MTP array
//   ptr_in_range() : 1 when a word pointer lies inside the writable range
package mtp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK,
    S_ERASE,
    S_E_WAIT,
    S_PROG,
    S_P_WAIT,
    S_VRD,
    S_V_WAIT,
    S_DONE,
    S_FAIL
  } mtp_wr_state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_VFY = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_OOR = 2'b11;

  localparam logic [4:0] PTR_LS  = 5'h04;
  localparam logic [4:0] PTR_KS  = 5'h05;
  localparam logic [4:0] PTR_PC  = 5'h07;
  localparam logic [4:0] PTR_EPC = 5'h08;

  localparam int unsigned EPC_MAX_WORDS = 6;
  // Last EPC word: 8 + 6 - 1 = 13.
  localparam logic [4:0] PTR_MAX = 5'd13;

  function automatic logic ptr_in_range(input logic [4:0] ptr);
    return (ptr <= PTR_MAX);
  endfunction

endpackage

// File: rtl/mtp_op_timer.sv
// mtp_op_timer: 8-bit operation timeout counter, shared with the init
// sequencer.
//   init_clk, rst_n : clock, asynchronous active-low reset
//   clr             : synchronous clear (wins over inc)
//   inc             : count one cycle; saturates at 8'hFF
//   limit           : timeout value
//   cnt             : current count
//   expired         : cnt == limit
module mtp_op_timer (
  input  logic       init_clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic [7:0] cnt,
  output logic       expired
);

  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == limit);

endmodule

// File: rtl/mtp_write.sv
// mtp_write: one-word MTP write controller. Each accepted request runs
// erase -> program -> read-back verify, retrying on verify mismatch, and ends
// with a one-cycle wr_done plus an error code.
//
// Build option: MTP_WR_VERIFY_EN. When undefined the verify read and the
// retry loop are removed: op_done in P_WAIT completes the write and
// vrd_pulse stays 0.
//
// Parameters: MAX_RETRY  - program attempts allowed after the first failed verify
//             OP_TIMEOUT - wait-state cycles before an operation is aborted
// Ports:
//   init_clk, rst_n           : clock, asynchronous active-low reset
//   wr_req, wr_pointer, wr_data : write request pulse, word address, data
//   op_done, mtp_data         : MTP operation-complete pulse, read-back data
//   mtp_addr, mtp_wdata       : latched address and data to the MTP
//   erase_pulse, prog_pulse, vrd_pulse : one-cycle MTP strobes
//   wr_busy, wr_done, wr_err, err_code : status back to the command layer
module mtp_write
  import mtp_pkg::*;
#(
  parameter int unsigned MAX_RETRY  = 3,
  parameter logic [7:0]  OP_TIMEOUT = 8'd255
) (
  input  logic        init_clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [4:0]  wr_pointer,
  input  logic [15:0] wr_data,
  input  logic        op_done,
  input  logic [15:0] mtp_data,
  output logic [4:0]  mtp_addr,
  output logic [15:0] mtp_wdata,
  output logic        erase_pulse,
  output logic        prog_pulse,
  output logic        vrd_pulse,
  output logic        wr_busy,
  output logic        wr_done,
  output logic        wr_err,
  output logic [1:0]  err_code
);

  mtp_wr_state_e state, state_d;

  logic       accept;
  logic       erase_d, prog_d, done_d, err_set;
  logic       tmr_clr, tmr_inc, tmr_expired;
  logic [1:0] fail_code, fail_code_d;
  logic [7:0] unused_tmr_cnt;

`ifdef MTP_WR_VERIFY_EN
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_inc;
  logic               vrd_d;
`else
  logic [15:0] unused_mtp_data;
  assign unused_mtp_data = mtp_data;
`endif

  mtp_op_timer u_op_timer (
    .init_clk (init_clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .inc      (tmr_inc),
    .limit    (OP_TIMEOUT),
    .cnt      (unused_tmr_cnt),
    .expired  (tmr_expired)
  );

  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    accept      = 1'b0;
    erase_d     = 1'b0;
    prog_d      = 1'b0;
    done_d      = 1'b0;
    err_set     = 1'b0;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
    fail_code_d = fail_code;
`ifdef MTP_WR_VERIFY_EN
    vrd_d       = 1'b0;
    retry_inc   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (wr_req) begin
          accept  = 1'b1;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (!ptr_in_range(mtp_addr)) begin
          fail_code_d = ERR_OOR;
          state_d     = S_FAIL;
        end else begin
          state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        erase_d = 1'b1;
        tmr_clr = 1'b1;
        state_d = S_E_WAIT;
      end
      S_E_WAIT: begin
        tmr_inc = 1'b1;
        // op_done is checked first so it wins over a same-cycle timeout.
        if (op_done) begin
          state_d = S_PROG;
        end else if (tmr_expired) begin
          fail_code_d = ERR_TMO;
          state_d     = S_FAIL;
        end
      end
      S_PROG: begin
        prog_d  = 1'b1;
        tmr_clr = 1'b1;
        state_d = S_P_WAIT;
      end
      S_P_WAIT: begin
        tmr_inc = 1'b1;
        if (op_done) begin
`ifdef MTP_WR_VERIFY_EN
          state_d = S_VRD;
`else
          state_d = S_DONE;
`endif
        end else if (tmr_expired) begin
          fail_code_d = ERR_TMO;
          state_d     = S_FAIL;
        end
      end
`ifdef MTP_WR_VERIFY_EN
      S_VRD: begin
        vrd_d   = 1'b1;
        tmr_clr = 1'b1;
        state_d = S_V_WAIT;
      end
      S_V_WAIT: begin
        tmr_inc = 1'b1;
        if (op_done) begin
          if (mtp_data == mtp_wdata) begin
            state_d = S_DONE;
          end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_d   = S_ERASE;
          end else begin
            fail_code_d = ERR_VFY;
            state_d     = S_FAIL;
          end
        end else if (tmr_expired) begin
          fail_code_d = ERR_TMO;
          state_d     = S_FAIL;
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        done_d  = 1'b1;
        err_set = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The failing code is parked in fail_code on the way into FAIL so that
  // err_code and wr_err change together with wr_done.
  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      erase_pulse <= 1'b0;
      prog_pulse  <= 1'b0;
      wr_busy     <= 1'b0;
      wr_done     <= 1'b0;
      wr_err      <= 1'b0;
      err_code    <= ERR_OK;
      fail_code   <= ERR_OK;
      mtp_addr    <= '0;
      mtp_wdata   <= '0;
    end else begin
      erase_pulse <= erase_d;
      prog_pulse  <= prog_d;
      wr_done     <= done_d;
      wr_busy     <= accept || (state != S_IDLE);
      fail_code   <= fail_code_d;
      if (accept) begin
        mtp_addr  <= wr_pointer;
        mtp_wdata <= wr_data;
        wr_err    <= 1'b0;
        err_code  <= ERR_OK;
      end else if (err_set) begin
        wr_err   <= 1'b1;
        err_code <= fail_code;
      end
    end
  end

`ifdef MTP_WR_VERIFY_EN
  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      vrd_pulse <= 1'b0;
      retry_cnt <= '0;
    end else begin
      vrd_pulse <= vrd_d;
      if (accept)         retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign vrd_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_mtp_write.sv
// tb_mtp_write: randomized self-checking bench for mtp_write. An MTP
// responder answers each strobe after a configured delay (or never), and a
// reference model derives strobe cycles, the wr_done cycle and the error
// code from the operation rules. Cycle n is the value seen after the n-th
// rising edge counted from the accepting edge (n = 0).
// Honours MTP_WR_VERIFY_EN the same way as the design.
module tb_mtp_write;

  localparam int unsigned MAX_RETRY = 3;
  localparam int          OP_TMO    = 255;

  logic        init_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0;
  logic [4:0]  wr_pointer = '0;
  logic [15:0] wr_data = '0;
  logic        op_done = 1'b0;
  logic [15:0] mtp_data = '0;
  logic [4:0]  mtp_addr;
  logic [15:0] mtp_wdata;
  logic        erase_pulse, prog_pulse, vrd_pulse;
  logic        wr_busy, wr_done, wr_err;
  logic [1:0]  err_code;

  mtp_write #(.MAX_RETRY(MAX_RETRY), .OP_TIMEOUT(8'd255)) dut (
    .init_clk    (init_clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_pointer  (wr_pointer),
    .wr_data     (wr_data),
    .op_done     (op_done),
    .mtp_data    (mtp_data),
    .mtp_addr    (mtp_addr),
    .mtp_wdata   (mtp_wdata),
    .erase_pulse (erase_pulse),
    .prog_pulse  (prog_pulse),
    .vrd_pulse   (vrd_pulse),
    .wr_busy     (wr_busy),
    .wr_done     (wr_done),
    .wr_err      (wr_err),
    .err_code    (err_code)
  );

  always #5 init_clk = ~init_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

`ifdef MTP_WR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  // Stimulus configuration for the current write.
  int          g_dly, g_bad, g_tmo_op, g_tmo_d, g_op, g_vidx;
  logic [15:0] g_data, g_mask;

  // Delay from strobe to op_done (in cycles) for the op-th strobe; 0 = never.
  function automatic int op_delay(input int op);
    return (op == g_tmo_op) ? g_tmo_d : g_dly;
  endfunction

  // MTP responder.
  int   r_d;
  logic r_vrd;
  initial begin
    forever begin
      @(negedge init_clk);
      if (rst_n && (erase_pulse || prog_pulse || vrd_pulse)) begin
        r_vrd = vrd_pulse;
        r_d   = op_delay(g_op);
        g_op++;
        if (r_d > 0) begin
          repeat (r_d - 1) @(negedge init_clk);
          if (r_vrd) begin
            mtp_data = (g_vidx < g_bad) ? (g_data ^ g_mask) : g_data;
            g_vidx++;
          end
          op_done = 1'b1;
          @(negedge init_clk);
          op_done = 1'b0;
        end
      end
    end
  end

  // Reference model.
  int exp_er[$], exp_pr[$], exp_vr[$];

  // One strobe-and-wait step. On entry t is the cycle the strobe state is
  // entered; on exit t is the cycle the next state is entered.
  task automatic ref_step(input int kind, inout int t, inout int op, output bit tmo);
    int s, d;
    s = t + 1;
    case (kind)
      0:       exp_er.push_back(s);
      1:       exp_pr.push_back(s);
      default: exp_vr.push_back(s);
    endcase
    d = op_delay(op);
    op++;
    if (d == 0 || d > OP_TMO + 1) begin
      tmo = 1'b1;
      t   = s + OP_TMO + 1;
    end else begin
      tmo = 1'b0;
      t   = s + d;
    end
  endtask

  task automatic ref_model(input logic [4:0] ptr, output int done, output logic [1:0] code);
    int t, op, misses;
    bit tmo, fin;
    exp_er.delete();
    exp_pr.delete();
    exp_vr.delete();
    code = 2'b00;
    if (ptr > 5'd13) begin
      done = 2;
      code = 2'b11;
      return;
    end
    t = 1; op = 0; misses = 0; fin = 1'b0; tmo = 1'b0;
    while (!fin) begin
      ref_step(0, t, op, tmo);
      if (!tmo) ref_step(1, t, op, tmo);
      if (!VERIFY) begin
        code = tmo ? 2'b10 : 2'b00;
        fin  = 1'b1;
      end else begin
        if (!tmo) ref_step(2, t, op, tmo);
        if (tmo) begin
          code = 2'b10;
          fin  = 1'b1;
        end else if (misses >= g_bad) begin
          code = 2'b00;
          fin  = 1'b1;
        end else begin
          misses++;
          if (misses > int'(MAX_RETRY)) begin
            code = 2'b01;
            fin  = 1'b1;
          end
        end
      end
    end
    done = t + 1;
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
    check({tag, ".count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic run_txn(input string name, input logic [4:0] ptr, input logic [15:0] data,
                         input int dly, input int bad, input int tmo_op, input int tmo_d,
                         input bit dup, output int got_done);
    int          exp_done, dup_at, cyc, n_done, busy_bad;
    logic [1:0]  exp_code, got_code, code_after;
    logic        got_err, err_after, busy_after;
    logic [4:0]  addr_after;
    logic [15:0] wdata_after;
    int          got_er[$], got_pr[$], got_vr[$];

    g_dly = dly; g_bad = bad; g_tmo_op = tmo_op; g_tmo_d = tmo_d;
    g_op = 0; g_vidx = 0; g_data = data;
    g_mask = 16'($urandom_range(1, 65535));
    ref_model(ptr, exp_done, exp_code);
    dup_at = dup ? int'($urandom_range(1, exp_done - 1)) : -1;

    got_done = -1; got_err = 1'b0; got_code = 2'b00; n_done = 0; busy_bad = 0;
    err_after = 1'b0; code_after = 2'b00; busy_after = 1'b1; addr_after = '0; wdata_after = '0;

    @(negedge init_clk);
    wr_pointer = ptr; wr_data = data; wr_req = 1'b1;
    @(posedge init_clk);
    cyc = 0;
    while (cyc <= exp_done + 1) begin
      @(negedge init_clk);
      if (cyc == dup_at) begin
        wr_req = 1'b1; wr_pointer = ptr ^ 5'h15; wr_data = ~data;
      end else begin
        wr_req = 1'b0;
      end
      if (erase_pulse) got_er.push_back(cyc);
      if (prog_pulse)  got_pr.push_back(cyc);
      if (vrd_pulse)   got_vr.push_back(cyc);
      if (wr_done) begin
        n_done++;
        if (got_done < 0) begin
          got_done = cyc; got_err = wr_err; got_code = err_code;
        end
      end
      if (cyc <= exp_done && !wr_busy) busy_bad++;
      if (cyc == exp_done + 1) begin
        busy_after = wr_busy; err_after = wr_err; code_after = err_code;
        addr_after = mtp_addr; wdata_after = mtp_wdata;
      end
      cyc++;
      if (cyc <= exp_done + 1) @(posedge init_clk);
    end
    wr_req = 1'b0;

    check({name, ".done_cycle"}, got_done, exp_done);
    check({name, ".done_pulses"}, n_done, 1);
    check({name, ".wr_err"}, got_err, (exp_code != 2'b00));
    check({name, ".err_code"}, got_code, exp_code);
    check({name, ".err_held"}, {err_after, code_after}, {(exp_code != 2'b00), exp_code});
    check({name, ".busy_gaps"}, busy_bad, 0);
    check({name, ".busy_after"}, busy_after, 1'b0);
    check({name, ".mtp_addr"}, addr_after, ptr);
    check({name, ".mtp_wdata"}, wdata_after, data);
    cmp_q({name, ".erase"}, got_er, exp_er);
    cmp_q({name, ".prog"}, got_pr, exp_pr);
    cmp_q({name, ".vrd"}, got_vr, exp_vr);
  endtask

  int          d_got;
  int          n_done_rst;
  logic [15:0] r_data;

  initial begin
    repeat (3) @(negedge init_clk);
    check("reset.outputs",
          {erase_pulse, prog_pulse, vrd_pulse, wr_busy, wr_done, wr_err, err_code},
          8'h00);
    check("reset.addr_data", {mtp_addr, mtp_wdata}, 21'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge init_clk);

    // Nominal write, one-cycle MTP response.
    run_txn("basic", 5'h07, 16'h3000, 1, 0, -1, 0, 1'b0, d_got);
    check("basic.latency", d_got, VERIFY ? 8 : 6);

    run_txn("retry2", 5'h08, 16'hA5C3, 1, 2, -1, 0, 1'b0, d_got);
    run_txn("allbad", 5'h04, 16'h1234, 2, 99, -1, 0, 1'b0, d_got);
    run_txn("tmo_prog", 5'h05, 16'h0F0F, 1, 0, 1, 0, 1'b0, d_got);
    run_txn("tmo_edge", 5'h05, 16'hF0F0, 1, 0, 1, OP_TMO + 1, 1'b0, d_got);
    run_txn("oor", 5'd14, 16'hBEEF, 1, 0, -1, 0, 1'b1, d_got);
    check("oor.latency", d_got, 2);
    run_txn("max_ptr", 5'd13, 16'h5555, 3, 0, -1, 0, 1'b1, d_got);

    for (int i = 0; i < 30; i++) begin
      int   dly, bad, tmo_op, tmo_d;
      logic [4:0] ptr;
      ptr    = 5'($urandom_range(0, 16));
      r_data = 16'($urandom);
      dly    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 20)) : int'($urandom_range(1, 4));
      bad    = int'($urandom_range(0, 5));
      tmo_op = -1; tmo_d = 0;
      if ($urandom_range(0, 7) == 0) begin
        tmo_op = int'($urandom_range(0, 5));
        tmo_d  = ($urandom_range(0, 1) == 0) ? 0 : OP_TMO + 1;
      end
      run_txn($sformatf("rnd%0d", i), ptr, r_data, dly, bad, tmo_op, tmo_d,
              1'($urandom_range(0, 1)), d_got);
    end

    // Reset while the erase strobe is high; MTP never answers the erase.
    g_dly = 1; g_bad = 0; g_tmo_op = 0; g_tmo_d = 0; g_op = 0; g_vidx = 0;
    @(negedge init_clk);
    wr_pointer = 5'h08; wr_data = 16'h7777; wr_req = 1'b1;
    @(posedge init_clk);
    @(negedge init_clk);
    wr_req = 1'b0;
    repeat (2) @(negedge init_clk);
    check("rst_mid.erase_seen", erase_pulse, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs",
          {erase_pulse, prog_pulse, vrd_pulse, wr_busy, wr_done, wr_err, err_code},
          8'h00);
    check("rst_mid.addr_data", {mtp_addr, mtp_wdata}, 21'h0);
    @(negedge init_clk);
    rst_n = 1'b1;
    n_done_rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge init_clk);
      if (wr_done || wr_busy || erase_pulse || prog_pulse) n_done_rst++;
    end
    check("rst_mid.idle_after", n_done_rst, 0);

    run_txn("post_rst", 5'h07, 16'h3000, 1, 0, -1, 0, 1'b0, d_got);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
